// File: rtl/pipe_watch_pkg.sv
// Shared constants and stage indices for the pipeline watchpoint tracker.
package pipe_watch_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;
  localparam int NUM_STG    = 5;

  typedef enum logic [2:0] {
    STG_IF  = 3'd0,
    STG_ID  = 3'd1,
    STG_EX  = 3'd2,
    STG_MEM = 3'd3,
    STG_WB  = 3'd4
  } stage_e;

  // Value at which the retired-hit counter stops counting.
  localparam logic [DEF_CNT_W-1:0] HIT_SAT = '1;

endpackage

// File: rtl/pipe_watch_if.sv
// Pipeline-side bundle of the watchpoint tracker: config, pipeline status in, match lines out.
interface pipe_watch_if
  import pipe_watch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
);
  logic              cfg_we;
  logic [DATA_W-1:0] cfg_instr;
  logic [DATA_W-1:0] cfg_mask;
  logic [DATA_W-1:0] cfg_result;
  logic              watch_en;
  logic [DATA_W-1:0] instr_if;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] alu_result_mem;
  logic              cnt_clr;
  logic              match_if;
  logic              match_id;
  logic              match_ex;
  logic              match_mem;
  logic              match_wb;
  logic [CNT_W-1:0]  hit_count;

  modport master (
    output cfg_we, cfg_instr, cfg_mask, cfg_result, watch_en, instr_if,
           stall, flush, alu_result_mem, cnt_clr,
    input  match_if, match_id, match_ex, match_mem, match_wb, hit_count
  );

  modport slave (
    input  cfg_we, cfg_instr, cfg_mask, cfg_result, watch_en, instr_if,
           stall, flush, alu_result_mem, cnt_clr,
    output match_if, match_id, match_ex, match_mem, match_wb, hit_count
  );
endinterface

// File: rtl/pipe_watch_stage_reg.sv
// One-bit stage tag register; clr beats hold, 1-cycle latency, no backpressure of its own.
module watch_stage_reg (
  input  logic clk,
  input  logic reset_n,
  input  logic hold,
  input  logic clr,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_watch.sv
// Watchpoint tag tracker IF->WB (match_if comb, +1 cycle per stage); obeys stall/flush, no backpressure.
// PIPE_WATCH_RESULT_EN additionally qualifies the MEM-stage tag with an ALU result compare.
module pipe_watch
  import pipe_watch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic         clk,
  input logic         reset_n,
  pipe_watch_if.slave bus
);

  logic [DATA_W-1:0]  watch_instr;
  logic [DATA_W-1:0]  watch_mask;
  logic               hit_if;
  logic               hit_mem;
  logic               tag_id;
  logic               tag_ex;
  logic               tag_mem;
  logic               tag_wb;
  logic [CNT_W-1:0]   hit_cnt;
  logic [NUM_STG-1:0] match_vec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      watch_instr <= '0;
      watch_mask  <= '0;
    end else if (bus.cfg_we) begin
      watch_instr <= bus.cfg_instr;
      watch_mask  <= bus.cfg_mask;
    end
  end

  // The cleared mask matches everything, so reset must also silence the IF line.
  assign hit_if = reset_n && bus.watch_en &&
                  ((bus.instr_if & watch_mask) == (watch_instr & watch_mask));

  watch_stage_reg u_id (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (bus.stall),
    .clr     (bus.flush),
    .d       (hit_if),
    .q       (tag_id)
  );

  // EX takes a bubble on stall and is killed on flush.
  watch_stage_reg u_ex (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (1'b0),
    .clr     (bus.flush | bus.stall),
    .d       (tag_id),
    .q       (tag_ex)
  );

`ifdef PIPE_WATCH_RESULT_EN
  logic [DATA_W-1:0] watch_result;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      watch_result <= '0;
    end else if (bus.cfg_we) begin
      watch_result <= bus.cfg_result;
    end
  end

  assign hit_mem = tag_mem && (bus.alu_result_mem == watch_result);
`else
  logic unused_result;
  assign unused_result = ^{bus.cfg_result, bus.alu_result_mem};
  assign hit_mem       = tag_mem;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_mem <= 1'b0;
      tag_wb  <= 1'b0;
    end else begin
      tag_mem <= tag_ex;
      tag_wb  <= hit_mem;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt <= '0;
    end else if (bus.cnt_clr) begin
      hit_cnt <= '0;
    end else if (tag_wb && !(&hit_cnt)) begin
      hit_cnt <= hit_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    match_vec          = '0;
    match_vec[STG_IF]  = hit_if;
    match_vec[STG_ID]  = tag_id;
    match_vec[STG_EX]  = tag_ex;
    match_vec[STG_MEM] = hit_mem;
    match_vec[STG_WB]  = tag_wb;
  end

  assign bus.match_if  = match_vec[STG_IF];
  assign bus.match_id  = match_vec[STG_ID];
  assign bus.match_ex  = match_vec[STG_EX];
  assign bus.match_mem = match_vec[STG_MEM];
  assign bus.match_wb  = match_vec[STG_WB];
  assign bus.hit_count = hit_cnt;

endmodule
